// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - BHT direction predictor with execute-stage branch resolution and perf counters
module branch_predict_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2,
  parameter int PERF_BITS   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [XLEN-1:0]      fetch_pc,
  output logic                 pred_taken,
  input  logic                 ex_valid,
  input  logic                 ex_branch,
  input  logic                 ex_jump,
  input  logic [2:0]           ex_funct3,
  input  logic                 ex_sf,
  input  logic                 ex_zf,
  input  logic                 ex_vf,
  input  logic                 ex_cf,
  input  logic [XLEN-1:0]      ex_pc,
  input  logic [XLEN-1:0]      ex_target,
  input  logic                 ex_pred_taken,
  output logic                 actual_taken,
  output logic                 mispredict,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 illegal_branch,
  output logic [PERF_BITS-1:0] perf_branches,
  output logic [PERF_BITS-1:0] perf_mispredicts
);

  localparam int IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;
  // Weakly-not-taken: MSB clear, every lower bit set.
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic [CTR_BITS-1:0] bht [BHT_ENTRIES];

  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             cond_taken;
  logic             funct3_legal;
  logic             resolve;
  logic             bht_update;
  logic [CTR_BITS-1:0] ex_ctr;

  assign fetch_idx  = fetch_pc[IDX_W+1:2];
  assign ex_idx     = ex_pc[IDX_W+1:2];
  assign ex_ctr     = bht[ex_idx];

  // No write bypass: a same-cycle update becomes visible on the next cycle.
  assign pred_taken = bht[fetch_idx][CTR_BITS-1];

  // Decode the branch condition from the subtract flags of rs1-rs2.
  always_comb begin
    cond_taken   = 1'b0;
    funct3_legal = 1'b1;
    case (ex_funct3)
      3'b000:  cond_taken = ex_zf;
      3'b001:  cond_taken = ~ex_zf;
      3'b100:  cond_taken = (ex_sf != ex_vf);
      3'b101:  cond_taken = (ex_sf == ex_vf);
      3'b110:  cond_taken = ~ex_cf;
      3'b111:  cond_taken = ex_cf;
      default: funct3_legal = 1'b0;
    endcase
  end

  assign resolve        = ex_valid & (ex_branch | ex_jump);
  assign actual_taken   = ex_valid & (ex_jump | (ex_branch & funct3_legal & cond_taken));
  assign illegal_branch = ex_valid & ex_branch & ~ex_jump & ~funct3_legal;
  assign mispredict     = resolve & (actual_taken != ex_pred_taken);
  assign redirect_pc    = actual_taken ? ex_target : (ex_pc + XLEN'(4));
  // Only legal conditional branches train the table; jumps never do.
  assign bht_update     = ex_valid & ex_branch & ~ex_jump & funct3_legal;

  // Train the saturating counter of the resolved branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= CTR_INIT;
      end
    end else if (bht_update) begin
      if (actual_taken && (ex_ctr != '1)) begin
        bht[ex_idx] <= ex_ctr + CTR_BITS'(1);
      end else if (!actual_taken && (ex_ctr != '0)) begin
        bht[ex_idx] <= ex_ctr - CTR_BITS'(1);
      end
    end
  end

  // Saturating event counters for resolved control transfers and mispredicts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (resolve && (perf_branches != '1)) begin
        perf_branches <= perf_branches + PERF_BITS'(1);
      end
      if (mispredict && (perf_mispredicts != '1)) begin
        perf_mispredicts <= perf_mispredicts + PERF_BITS'(1);
      end
    end
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
Successor to the combinational branch-condition resolver. Adds a parametrised branch history table (BHT) of saturating counters. The fetch stage gets a direction prediction from it. In execute, the block resolves the actual outcome from ALU flags, flags direction mispredicts with a redirect PC, trains the BHT, and keeps saturating performance counters.

Parameters:
XLEN, 32, address/data width
BHT_ENTRIES, 64, number of BHT entries; power of 2, >=2; index = pc[log2(BHT_ENTRIES)+1:2]
CTR_BITS, 2, saturating counter width (>=1); taken prediction = counter MSB
PERF_BITS, 32, width of performance counters

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_pc  in  XLEN  PC being fetched
pred_taken  out  1  predicted direction for fetch_pc (combinational read)
ex_valid  in  1  execute-stage instruction valid (not bubble/flushed)
ex_branch  in  1  instruction is a conditional branch
ex_jump  in  1  instruction is JAL/JALR
ex_funct3  in  3  branch funct3
ex_sf, ex_zf, ex_vf, ex_cf  in  1 each  ALU flags from rs1-rs2 subtract
ex_pc  in  XLEN  PC of execute-stage instruction
ex_target  in  XLEN  computed branch/jump target
ex_pred_taken  in  1  prediction carried down the pipe with this instruction
actual_taken  out  1  resolved direction
mispredict  out  1  direction mismatch; pipeline must flush
redirect_pc  out  XLEN  correct next PC when mispredict=1
illegal_branch  out  1  ex_branch with funct3 010/011
perf_branches  out  PERF_BITS  resolved branch+jump count
perf_mispredicts  out  PERF_BITS  mispredict count

Behaviour:
- Reset (async, rst_n=0): every BHT entry = weakly-not-taken (MSB=0, other bits 1; 2'b01 for CTR_BITS=2; 1'b0 for CTR_BITS=1); perf counters = 0. Combinational outputs follow their inputs; with ex_valid=0 they are actual_taken=0, mispredict=0, redirect_pc=ex_pc+4, illegal_branch=0.
- Resolution is combinational, same cycle. resolve = ex_valid & (ex_branch | ex_jump).
- ex_jump has priority: actual_taken=1.
- Otherwise, with ex_branch, by funct3:
  - 000 BEQ: zf
  - 001 BNE: ~zf
  - 100 BLT: sf!=vf
  - 101 BGE: sf==vf
  - 110 BLTU: ~cf
  - 111 BGEU: cf
  - 010/011: actual_taken=0, illegal_branch=1
- mispredict = resolve & (actual_taken != ex_pred_taken). Direction only; there is no target check.
- redirect_pc = actual_taken ? ex_target : ex_pc+4 (mod 2^XLEN, wraps).
- BHT update on the rising edge when ex_valid & ex_branch & funct3 legal. Entry at ex_pc index: +1 if taken, -1 if not, saturating at all-ones / zero. Jumps and illegal funct3 do not update.
- Read/write same index in one cycle: pred_taken returns the pre-update value (no bypass); the new value is visible next cycle.
- Perf counters, on the clock edge:
  - perf_branches += 1 when resolve.
  - perf_mispredicts += 1 when mispredict.
  - Both saturate at all-ones, no wrap.
  - An illegal-funct3 branch counts as resolved.
- ex_valid=0 suppresses all outputs except redirect_pc, and blocks all state updates.
- Reset asserted mid-operation immediately clears state; an update pending on that edge is dropped.

Test Plan:
1. Reset then fetch_pc=0x100 -> pred_taken=0. BEQ at ex_pc=0x100, zf=1, ex_pred_taken=0, ex_target=0x80 -> actual_taken=1, mispredict=1, redirect_pc=0x80. Next cycle pred_taken(0x100)=1.
2. Same BEQ taken 3 more times, then BEQ zf=0 with ex_pred_taken=1 -> counter 11->10, pred stays 1, mispredict=1, redirect_pc=0x104. A second not-taken gives 01, pred 0.
3. Sweep funct3 with flags: BLT sf=1,vf=0 -> taken; BGE same -> not; BLTU cf=0 -> taken; BGEU cf=0 -> not; funct3=010 -> illegal_branch=1, BHT unchanged.
4. JAL, ex_pred_taken=0 -> mispredict=1, redirect_pc=ex_target, BHT entry unchanged; perf_branches=1, perf_mispredicts=1.
5. Alias/boundary: BHT_ENTRIES=64, ex_pc=0x000 and 0x100 share index 0 -> training one changes the other's prediction. ex_pc=0xFFFFFFFC not taken -> redirect_pc=0x0. Same-cycle read/write of one index returns the old value.
6. ex_valid=0 with a taking branch -> no mispredict, counters unchanged. Assert rst_n low mid-sequence -> BHT back to 01, perf counters 0 without a clock edge.
